// File: rtl/nrad.sv
// ---------------------------------------------------------------------------
// nrad -- pipelined non-restoring array divider (4-bit / 2-bit, unsigned)
//
// Computes X / Y as a 4-row array of controlled add/subtract cells, one row
// per quotient bit.
//
// Pipeline structure:
//   - An input capture stage registers X, Y and in_valid.
//   - Each of the four rows is followed by its own register.
//   - The remainder correction and the divide-by-zero override sit in
//     combinational logic after the last row register.
// An operation captured on edge t is presented on the outputs after edge t+4.
// A new operation may enter on every clock; there is no stall.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset, clears every stage
//   in_valid  in   1  X/Y carry an operation this cycle
//   X         in   4  unsigned dividend
//   Y         in   2  unsigned divisor
//   out_valid out  1  Q/R/ovf/dz carry a result this cycle
//   Q         out  3  low three bits of floor(X/Y)
//   R         out  3  X mod Y, zero-extended
//   ovf       out  1  true quotient does not fit in three bits
//   dz        out  1  divisor was zero
// ---------------------------------------------------------------------------
module nrad (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] X,
   input  logic [1:0] Y,
   output logic       out_valid,
   output logic [2:0] Q,
   output logic [2:0] R,
   output logic       ovf,
   output logic       dz
);

   // Three-bit ripple add/subtract built from G/P full-adder cells.
   // With sub=1, b is inverted and the carry-in is 1, giving a - b.
   function automatic logic [2:0] add_sub(input logic [2:0] a,
                                          input logic [2:0] b,
                                          input logic       sub);
      logic [2:0] bb;
      logic [2:0] s;
      logic       c;
      logic       g;
      logic       p;
      bb = b ^ {3{sub}};
      c  = sub;
      for (int i = 0; i < 3; i++) begin
         g    = a[i] & bb[i];
         p    = a[i] ^ bb[i];
         s[i] = p ^ c;
         c    = g | (p & c);
      end
      return s;
   endfunction

   // Stage 0: captured operands.
   logic       v0, dz0;
   logic [3:0] x0;
   logic [1:0] y0;

   // Stages 1..4: one register set per row.
   // The remaining dividend bits shrink by one bit per stage, and the
   // quotient grows by one bit per stage.
   logic       v1, v2, v3, v4;
   logic       dz1, dz2, dz3, dz4;
   logic [1:0] y1, y2, y3, y4;
   logic [2:0] pr1, pr2, pr3, pr4;
   logic [2:0] x1;
   logic [1:0] x2;
   logic       x3;
   logic       q1;
   logic [1:0] q2;
   logic [2:0] q3;
   logic [3:0] q4;

   // Row results.
   // The partial remainder is 3-bit two's complement. Intermediate shifts
   // can wrap, but every row result lies in [-Y, Y-1], so the wrap is harmless.
   // The first row starts from a zero partial remainder, so it always
   // subtracts. Each later row adds when the previous remainder was
   // negative and subtracts otherwise.
   logic [2:0] row3, row2, row1, row0;
   assign row3 = add_sub({2'b00, x0[3]},     {1'b0, y0}, 1'b1);
   assign row2 = add_sub({pr1[1:0], x1[2]},  {1'b0, y1}, ~pr1[2]);
   assign row1 = add_sub({pr2[1:0], x2[1]},  {1'b0, y2}, ~pr2[2]);
   assign row0 = add_sub({pr3[1:0], x3},     {1'b0, y3}, ~pr3[2]);

   // Pipeline registers.
   // Data moves on every edge regardless of valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0 <= 1'b0; dz0 <= 1'b0; x0 <= '0; y0 <= '0;
         v1 <= 1'b0; dz1 <= 1'b0; x1 <= '0; y1 <= '0; pr1 <= '0; q1 <= 1'b0;
         v2 <= 1'b0; dz2 <= 1'b0; x2 <= '0; y2 <= '0; pr2 <= '0; q2 <= '0;
         v3 <= 1'b0; dz3 <= 1'b0; x3 <= 1'b0; y3 <= '0; pr3 <= '0; q3 <= '0;
         v4 <= 1'b0; dz4 <= 1'b0; y4 <= '0; pr4 <= '0; q4 <= '0;
      end else begin
         v0  <= in_valid;
         dz0 <= (Y == 2'd0);
         x0  <= X;
         y0  <= Y;

         v1  <= v0;  dz1 <= dz0; y1 <= y0; x1 <= x0[2:0];
         pr1 <= row3; q1 <= ~row3[2];

         v2  <= v1;  dz2 <= dz1; y2 <= y1; x2 <= x1[1:0];
         pr2 <= row2; q2 <= {q1, ~row2[2]};

         v3  <= v2;  dz3 <= dz2; y3 <= y2; x3 <= x2[0];
         pr3 <= row1; q3 <= {q2, ~row1[2]};

         v4  <= v3;  dz4 <= dz3; y4 <= y3;
         pr4 <= row0; q4 <= {q3, ~row0[2]};
      end
   end

   // Final stage.
   // A negative final remainder is pulled back into [0, Y-1] by adding Y.
   // The quotient bits are already exact. A zero divisor overrides the
   // array result entirely.
   logic [2:0] rem_fixed;
   assign rem_fixed = pr4[2] ? add_sub(pr4, {1'b0, y4}, 1'b0) : pr4;

   assign out_valid = v4;
   assign dz        = dz4;
   assign Q         = dz4 ? 3'b111 : q4[2:0];
   assign R         = dz4 ? 3'b000 : rem_fixed;
   assign ovf       = dz4 ? 1'b0   : q4[3];

endmodule

// File: tb/tb_nrad.sv
// ---------------------------------------------------------------------------
// tb_nrad -- self-checking bench for the nrad pipelined divider.
// Drives inputs on the falling edge and samples outputs on the next falling
// edge. Expected results sit in a queue, so each result is compared four
// edges after its operation is launched.
// ---------------------------------------------------------------------------
module tb_nrad;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] X;
   logic [1:0] Y;
   logic       out_valid;
   logic [2:0] Q;
   logic [2:0] R;
   logic       ovf;
   logic       dz;

   int tests;
   int fails;

   typedef struct {
      logic       v;
      logic [2:0] q;
      logic [2:0] r;
      logic       ovf;
      logic       dz;
   } exp_t;

   typedef struct {
      logic [3:0] x;
      logic [1:0] y;
      logic [2:0] q;
      logic [2:0] r;
      logic       ovf;
      logic       dz;
   } vec_t;

   exp_t pending[$];
   vec_t vecs[12];

   nrad dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .X(X), .Y(Y),
      .out_valid(out_valid), .Q(Q), .R(R), .ovf(ovf), .dz(dz)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model, computed directly with integer division.
   function automatic exp_t refModel(input logic v, input int x, input int y);
      exp_t e;
      int   full;
      e.v = v;
      if (y == 0) begin
         e.q = 3'd7; e.r = 3'd0; e.ovf = 1'b0; e.dz = 1'b1;
      end else begin
         full  = x / y;
         e.q   = full[2:0];
         e.r   = 3'(x % y);
         e.ovf = (full >= 8);
         e.dz  = 1'b0;
      end
      return e;
   endfunction

   // Refills the expectation queue with four empty slots.
   // This matches the pipeline contents right after a reset.
   task automatic clearModel();
      exp_t e;
      e = '{v: 1'b0, q: 3'd0, r: 3'd0, ovf: 1'b0, dz: 1'b0};
      pending.delete();
      for (int i = 0; i < 4; i++) pending.push_back(e);
   endtask

   // Compares the current outputs against one expected entry.
   task automatic checkOutput(input exp_t e, input string name);
      tests++;
      if (out_valid !== e.v) begin
         fails++;
         $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, e.v);
      end
      tests++;
      if (e.v) begin
         if (Q !== e.q || R !== e.r || ovf !== e.ovf || dz !== e.dz) begin
            fails++;
            $display("[TB] FAIL %s result: got Q=%0d R=%0d ovf=%b dz=%b expected Q=%0d R=%0d ovf=%b dz=%b",
                     name, Q, R, ovf, dz, e.q, e.r, e.ovf, e.dz);
         end
      end else if ($isunknown({Q, R, ovf, dz})) begin
         fails++;
         $display("[TB] FAIL %s unknown: got Q=%b R=%b ovf=%b dz=%b expected no X/Z",
                  name, Q, R, ovf, dz);
      end
   endtask

   // Launches one beat, advances a clock, and checks the beat that matures.
   task automatic applyStimulus(input logic v, input logic [3:0] x,
                                input logic [1:0] y, input exp_t e,
                                input string name);
      in_valid = v;
      X        = x;
      Y        = y;
      pending.push_back(e);
      @(posedge clk);
      @(negedge clk);
      checkOutput(pending.pop_front(), name);
   endtask

   // Checks that every output is forced to zero.
   task automatic checkReset(input string name);
      tests++;
      if (out_valid !== 1'b0 || Q !== 3'd0 || R !== 3'd0 || ovf !== 1'b0 || dz !== 1'b0) begin
         fails++;
         $display("[TB] FAIL %s: got v=%b Q=%0d R=%0d ovf=%b dz=%b expected all zero",
                  name, out_valid, Q, R, ovf, dz);
      end
   endtask

   task automatic idle(input int n, input string name);
      exp_t e;
      e = refModel(1'b0, 0, 1);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 2'd1, e, name);
   endtask

   initial begin
      exp_t e;
      logic [3:0] rx;
      logic [1:0] ry;
      logic       rv;

      tests = 0;
      fails = 0;

      // Hand-derived vectors: {x, y, q, r, ovf, dz}.
      vecs[0]  = '{4'd13, 2'd3, 3'd4, 3'd1, 1'b0, 1'b0};
      vecs[1]  = '{4'd15, 2'd1, 3'd7, 3'd0, 1'b1, 1'b0};
      vecs[2]  = '{4'd7,  2'd2, 3'd3, 3'd1, 1'b0, 1'b0};
      vecs[3]  = '{4'd9,  2'd0, 3'd7, 3'd0, 1'b0, 1'b1};
      vecs[4]  = '{4'd8,  2'd3, 3'd2, 3'd2, 1'b0, 1'b0};
      vecs[5]  = '{4'd0,  2'd3, 3'd0, 3'd0, 1'b0, 1'b0};
      vecs[6]  = '{4'd8,  2'd1, 3'd0, 3'd0, 1'b1, 1'b0};
      vecs[7]  = '{4'd14, 2'd3, 3'd4, 3'd2, 1'b0, 1'b0};
      vecs[8]  = '{4'd15, 2'd2, 3'd7, 3'd1, 1'b0, 1'b0};
      vecs[9]  = '{4'd12, 2'd1, 3'd4, 3'd0, 1'b1, 1'b0};
      vecs[10] = '{4'd0,  2'd0, 3'd7, 3'd0, 1'b0, 1'b1};
      vecs[11] = '{4'd5,  2'd3, 3'd1, 3'd2, 1'b0, 1'b0};

      // Reset held with a valid operation presented.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      X        = 4'd13;
      Y        = 2'd3;
      repeat (3) @(negedge clk);
      checkReset("reset_hold");
      rst_n = 1'b1;
      clearModel();

      // First operation after release, then the drain.
      e = '{v: 1'b1, q: 3'd4, r: 3'd1, ovf: 1'b0, dz: 1'b0};
      applyStimulus(1'b1, 4'd13, 2'd3, e, "first_op");
      idle(4, "first_op_drain");

      // Directed table, issued back-to-back.
      foreach (vecs[i]) begin
         e = '{v: 1'b1, q: vecs[i].q, r: vecs[i].r, ovf: vecs[i].ovf, dz: vecs[i].dz};
         applyStimulus(1'b1, vecs[i].x, vecs[i].y, e, $sformatf("vec%0d", i));
      end
      idle(4, "vec_drain");

      // Exhaustive sweep over nonzero divisors, one operation per cycle.
      for (int x = 0; x < 16; x++) begin
         for (int y = 1; y < 4; y++) begin
            applyStimulus(1'b1, 4'(x), 2'(y), refModel(1'b1, x, y),
                          $sformatf("sweep_%0d_%0d", x, y));
         end
      end
      idle(4, "sweep_drain");

      // Random traffic, including zero divisors and bubbles.
      for (int i = 0; i < 300; i++) begin
         rv = ($urandom_range(0, 3) != 0);
         rx = 4'($urandom_range(0, 15));
         ry = 2'($urandom_range(0, 3));
         applyStimulus(rv, rx, ry, refModel(rv, int'(rx), int'(ry)), "random");
      end
      idle(4, "random_drain");

      // Reset while three operations are in flight.
      // None of them may emerge.
      for (int i = 0; i < 3; i++) begin
         e = refModel(1'b1, 10 + i, 3);
         applyStimulus(1'b1, 4'(10 + i), 2'd3, e, "midflight_launch");
      end
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkReset("midflight_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkReset("midflight_reset_held");
      rst_n = 1'b1;
      clearModel();
      idle(6, "midflight_after");
      applyStimulus(1'b1, 4'd11, 2'd2, refModel(1'b1, 11, 2), "post_reset_op");
      idle(4, "post_reset_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nrad.md
Name: nrad

Overview:
- Pipelined non-restoring array divider: 4-bit unsigned dividend X divided by 2-bit unsigned divisor Y, producing quotient Q and remainder R.
- Built as 4 rows of controlled add/subtract cells, one row per quotient bit. Cells are full-adder style: G = a&b, P = a^b, sum = a^b^cin, cout = G | (P&cin).
- Each row is registered, so the block accepts one operation per clock.
- Used as the small arithmetic divider datapath in the ALU area.

Parameters:
- None. Widths are fixed at X=4, Y=2, Q=3, R=3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  X/Y are valid this cycle
- X  in  4  unsigned dividend
- Y  in  2  unsigned divisor
- out_valid  out  1  Q/R/ovf/dz are valid this cycle
- Q  out  3  quotient, low 3 bits of floor(X/Y)
- R  out  3  remainder X mod Y, zero-extended
- ovf  out  1  true quotient > 7
- dz  out  1  divide by zero (Y == 0)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0, all pipeline registers clear. Q=0, R=0, ovf=0, dz=0, out_valid=0.
- Sampling: X, Y and in_valid are captured on every rising edge. There is no stall or backpressure, and a new operation may enter every cycle.
- Latency: exactly 4 cycles. An operation captured at edge t appears on the outputs after edge t+4. out_valid is in_valid delayed by 4 stages.
- Invalid beats: when in_valid=0 the data still flows through the pipeline, but out_valid=0. Outputs carry don't-care values that must not be X.
- Algorithm:
  - Partial remainder is 3-bit two's complement and starts at 0.
  - Each row i (i = 3 down to 0):
    - Shift the partial remainder left and bring in X[i].
    - If the previous partial remainder was non-negative (or this is the first row), subtract {0,Y}. Otherwise add {0,Y}.
    - Quotient bit q[i] = NOT sign of the result.
  - Row 3 always subtracts.
- Final correction, in the stage-4 logic: if the final partial remainder is negative, add {0,Y} to it to form R. The quotient bits need no correction.
- Results:
  - R = X mod Y; R[2] is always 0.
  - Full quotient q[3:0] = floor(X/Y).
  - Q = q[2:0]; ovf = q[3].
- Divide by zero: Y=0 gives dz=1, Q=3'b111, R=3'b000, ovf=0. This is forced in the last stage from a pipelined copy of (Y==0); the array result is ignored.
- Reset mid-operation: any in-flight operations are discarded and out_valid stays 0 until 4 cycles after the first valid input following reset release.
- Each row's registers carry the partial remainder, the remaining dividend bits, Y, the quotient bits computed so far, the valid bit and the dz bit.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> all outputs 0, out_valid=0. Release, apply X=13, Y=3 -> four edges later Q=4, R=1, ovf=0, dz=0, out_valid=1.
- Exhaustive sweep: X=0..15, Y=1..3, one operation per cycle back-to-back -> every result equals floor(X/Y)[2:0] and X mod Y, in order, each with 4-cycle latency. ovf=1 exactly for (8..15)/1, (14,15)/1 excluded nowhere — i.e. whenever X/Y ≥ 8.
- Overflow: X=15, Y=1 -> Q=7, R=0, ovf=1. X=7, Y=2 -> Q=3, R=1, ovf=0.
- Divide by zero: X=9, Y=0 -> dz=1, Q=7, R=0, ovf=0.
- Negative-remainder path: X=8, Y=3 -> Q=2, R=2 (exercises the final correction add). X=0, Y=3 -> Q=0, R=0.
- Reset mid-flight: assert rst_n=0 two cycles after launching 3 operations -> no out_valid pulse appears for any of them.
